// File: rtl/split_solve_sched_if.sv
// rtl/split_solve_sched_if.sv - candidate-fetch and shared-checker handshake bundle
interface split_solve_sched_if #(
  parameter int NUM_SPLITS = 8,
  parameter int CAND_W     = 32
);
  localparam int SEL_W = $clog2(NUM_SPLITS);

  logic              cand_req;
  logic              cand_vld;
  logic [CAND_W-1:0] cand_data;
  logic              chk_req;
  logic [SEL_W-1:0]  chk_sel;
  logic [CAND_W-1:0] chk_vec;
  logic              chk_ack;
  logic              chk_pass;

  // scheduler side
  modport master (
    output cand_req,
    input  cand_vld,
    input  cand_data,
    output chk_req,
    output chk_sel,
    output chk_vec,
    input  chk_ack,
    input  chk_pass
  );

  // generator / checker side
  modport slave (
    input  cand_req,
    output cand_vld,
    output cand_data,
    input  chk_req,
    input  chk_sel,
    input  chk_vec,
    output chk_ack,
    output chk_pass
  );
endinterface

// File: rtl/split_solve_sched.sv
// rtl/split_solve_sched.sv - sequences candidates through enabled split checkers until one passes all
module split_solve_sched #(
  parameter int NUM_SPLITS = 8,
  parameter int CAND_W     = 32,
  parameter int MAX_TRIES  = 16,
  parameter int SEL_W      = $clog2(NUM_SPLITS),
  parameter int TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_SPLITS-1:0] split_mask,
  split_solve_sched_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  sat,
  output logic [CAND_W-1:0]     sol,
  output logic [TRY_W-1:0]      tries
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  state_t                state, state_n;
  logic [NUM_SPLITS-1:0] mask_q, mask_n;
  logic                  cand_req_q, cand_req_n;
  logic                  chk_req_q, chk_req_n;
  logic [SEL_W-1:0]      chk_sel_q, chk_sel_n;
  logic [CAND_W-1:0]     chk_vec_q, chk_vec_n;
  logic                  busy_n, done_n, sat_n;
  logic [CAND_W-1:0]     sol_n;
  logic [TRY_W-1:0]      tries_n;

  logic [SEL_W-1:0]      first_sel;
  logic [SEL_W-1:0]      next_sel;
  logic                  has_next;

  assign bus.cand_req = cand_req_q;
  assign bus.chk_req  = chk_req_q;
  assign bus.chk_sel  = chk_sel_q;
  assign bus.chk_vec  = chk_vec_q;

  // priority scans: lowest enabled split, and lowest enabled split above the current one
  always_comb begin
    first_sel = '0;
    next_sel  = '0;
    has_next  = 1'b0;
    for (int i = NUM_SPLITS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_sel = SEL_W'(i);
        if (i > int'(chk_sel_q)) begin
          next_sel = SEL_W'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  // next state and next value of every registered output
  always_comb begin
    state_n   = state;
    mask_n    = mask_q;
    chk_sel_n = chk_sel_q;
    chk_vec_n = chk_vec_q;
    sat_n     = sat;
    sol_n     = sol;
    tries_n   = tries;

    unique case (state)
      IDLE: begin
        if (start) begin
          mask_n  = split_mask;
          tries_n = '0;
          sat_n   = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        // an empty mask is trivially satisfied without consuming a candidate
        if (mask_q == '0) begin
          sat_n   = 1'b1;
          sol_n   = '0;
          tries_n = '0;
          state_n = DONE;
        end else if (cand_req_q && bus.cand_vld) begin
          chk_vec_n = bus.cand_data;
          tries_n   = tries + TRY_W'(1);
          chk_sel_n = first_sel;
          state_n   = CHECK;
        end
      end
      CHECK: begin
        if (chk_req_q && bus.chk_ack) begin
          if (bus.chk_pass) begin
            if (has_next) begin
              chk_sel_n = next_sel;
            end else begin
              sat_n   = 1'b1;
              sol_n   = chk_vec_q;
              state_n = DONE;
            end
          end else if (tries == TRY_W'(MAX_TRIES)) begin
            sat_n   = 1'b0;
            state_n = DONE;
          end else begin
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // request/status outputs are derived from the state being entered so they are registered
    cand_req_n = (state_n == FETCH) && (mask_n != '0);
    chk_req_n  = (state_n == CHECK);
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask_q     <= '0;
      cand_req_q <= 1'b0;
      chk_req_q  <= 1'b0;
      chk_sel_q  <= '0;
      chk_vec_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
      sol        <= '0;
      tries      <= '0;
    end else begin
      state      <= state_n;
      mask_q     <= mask_n;
      cand_req_q <= cand_req_n;
      chk_req_q  <= chk_req_n;
      chk_sel_q  <= chk_sel_n;
      chk_vec_q  <= chk_vec_n;
      busy       <= busy_n;
      done       <= done_n;
      sat        <= sat_n;
      sol        <= sol_n;
      tries      <= tries_n;
    end
  end

endmodule

// File: tb/tb_split_solve_sched.sv
// tb/tb_split_solve_sched.sv - table-driven scoreboard bench for split_solve_sched
module tb_split_solve_sched;
  localparam int NS = 8;
  localparam int CW = 32;
  localparam int MT = 16;
  localparam int SW = 3;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NS-1:0] split_mask = '0;
  logic          busy, done, sat;
  logic [CW-1:0] sol;
  logic [TW-1:0] tries;

  split_solve_sched_if #(.NUM_SPLITS(NS), .CAND_W(CW)) bus ();

  split_solve_sched #(
    .NUM_SPLITS(NS), .CAND_W(CW), .MAX_TRIES(MT), .SEL_W(SW), .TRY_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .split_mask(split_mask), .bus(bus),
    .busy(busy), .done(done), .sat(sat), .sol(sol), .tries(tries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] base;
    int          pass_from;
    int          fail_at;
    int          dmode;
    bit          poke;
    logic        exp_sat;
    logic [31:0] exp_sol;
    int          exp_tries;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        sat;
    logic [31:0] sol;
    int          tries;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] cfg_base = '0;
  int          cfg_pass_from = 0;
  int          cfg_fail_at = 0;
  int          cfg_dmode = 0;

  int          cand_hs, cand_wait, chk_wait;
  int          sel_log[$];
  bit          held, stab_bad;
  int          hsel;
  logic [31:0] hvec, kdiff;

  function automatic int pick_delay(input int mode);
    if (mode == 1) return int'($urandom_range(0, 5));
    if (mode == 2) return 3;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_sol"}, sol, 0);
    check({tag, "_tries"}, tries, 0);
    check({tag, "_cand_req"}, bus.cand_req, 0);
    check({tag, "_chk_req"}, bus.chk_req, 0);
    check({tag, "_chk_sel"}, bus.chk_sel, 0);
    check({tag, "_chk_vec"}, bus.chk_vec, 0);
  endtask

  // candidate generator model with optional stalls; value = base + handshake index
  initial begin
    bus.cand_vld  = 1'b0;
    bus.cand_data = '0;
    cand_hs   = 0;
    cand_wait = 0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        bus.cand_vld = 1'b0;
        cand_hs      = 0;
        cand_wait    = pick_delay(cfg_dmode);
      end else begin
        if (bus.cand_vld) begin
          cand_hs++;
          bus.cand_vld = 1'b0;
          cand_wait    = pick_delay(cfg_dmode);
        end
        if (bus.cand_req) begin
          if (cand_wait == 0) begin
            bus.cand_vld  = 1'b1;
            bus.cand_data = cfg_base + 32'(cand_hs);
          end else begin
            cand_wait--;
          end
        end
      end
    end
  end

  // shared checker model: candidate k fails at split cfg_fail_at while k < cfg_pass_from
  initial begin
    bus.chk_ack  = 1'b0;
    bus.chk_pass = 1'b0;
    chk_wait = 0;
    held     = 1'b0;
    stab_bad = 1'b0;
    hsel     = 0;
    hvec     = '0;
    kdiff    = '0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        bus.chk_ack  = 1'b0;
        bus.chk_pass = 1'b0;
        held         = 1'b0;
        chk_wait     = pick_delay(cfg_dmode);
        sel_log.delete();
      end else begin
        if (bus.chk_ack) begin
          bus.chk_ack  = 1'b0;
          bus.chk_pass = 1'b0;
          chk_wait     = pick_delay(cfg_dmode);
        end
        if (bus.chk_req) begin
          if (!held) begin
            held = 1'b1;
            hsel = int'(bus.chk_sel);
            hvec = bus.chk_vec;
          end else if (int'(bus.chk_sel) != hsel || bus.chk_vec != hvec) begin
            stab_bad = 1'b1;
          end
          if (chk_wait == 0) begin
            kdiff        = bus.chk_vec - cfg_base;
            bus.chk_pass = !(int'(kdiff) < cfg_pass_from && int'(bus.chk_sel) == cfg_fail_at);
            bus.chk_ack  = 1'b1;
            sel_log.push_back(int'(bus.chk_sel));
            held         = 1'b0;
          end else begin
            chk_wait--;
          end
        end
      end
    end
  end

  task automatic run_vec(input string name, input vec_t v);
    int   exp_sel[$];
    int   cyc;
    int   nbad;
    exp_t e;
    cfg_base      = v.base;
    cfg_pass_from = v.pass_from;
    cfg_fail_at   = v.fail_at;
    cfg_dmode     = v.dmode;
    for (int c = 0; c < v.exp_tries; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (v.mask[i]) begin
          exp_sel.push_back(i);
          if (c < v.pass_from && i == v.fail_at) break;
        end
      end
    end
    sb.push_back('{v.exp_sat, v.exp_sol, v.exp_tries});
    @(negedge clk);
    @(negedge clk);
    split_mask = v.mask;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    if (v.mask != 8'h00) check({name, "_cand_req_lat"}, bus.cand_req, 1);
    while (!done && cyc < 3000) begin
      if (v.poke && cyc == 3) begin
        start      = 1'b1;
        split_mask = 8'hFF;
      end else if (v.poke && cyc == 4) begin
        start      = 1'b0;
        split_mask = v.mask;
      end
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check({name, "_done_seen"}, done, 1);
    if (!done) return;
    check({name, "_sat"}, sat, e.sat);
    check({name, "_tries"}, tries, e.tries);
    if (e.sat) check({name, "_sol"}, sol, e.sol);
    if (v.exp_lat != 0) check({name, "_latency"}, cyc, v.exp_lat);
    check({name, "_cand_handshakes"}, cand_hs, e.tries);
    check({name, "_sel_count"}, sel_log.size(), exp_sel.size());
    nbad = 0;
    for (int i = 0; i < exp_sel.size() && i < sel_log.size(); i++)
      if (sel_log[i] != exp_sel[i]) nbad++;
    check({name, "_sel_order"}, nbad, 0);
    check({name, "_stable"}, stab_bad, 0);
    if (v.poke) begin
      start      = 1'b1;
      split_mask = 8'hFF;
    end
    @(negedge clk);
    start      = 1'b0;
    split_mask = v.mask;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_busy_fall"}, busy, 0);
    check({name, "_no_refetch"}, bus.cand_req, 0);
    check({name, "_sat_held"}, sat, e.sat);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t post;
    int   cyc;
    bit   seen;
    vecs[0] = '{8'h05, 32'hA5A5_0001, 0,   0, 0, 1'b0, 1'b1, 32'hA5A5_0001, 1,  4};
    vecs[1] = '{8'hFF, 32'h1000_0000, 1,   3, 0, 1'b0, 1'b1, 32'h1000_0001, 2,  15};
    vecs[2] = '{8'hFF, 32'hC0DE_0000, 100, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 16, 33};
    vecs[3] = '{8'h00, 32'h0000_0000, 0,   0, 0, 1'b0, 1'b1, 32'h0000_0000, 0,  2};
    vecs[4] = '{8'h90, 32'h1234_5678, 2,   7, 1, 1'b1, 1'b1, 32'h1234_567A, 3,  0};
    vecs[5] = '{8'h80, 32'h0000_0005, 0,   7, 1, 1'b0, 1'b1, 32'h0000_0005, 1,  0};
    vecs[6] = '{8'h5A, 32'h0BAD_0000, 15,  4, 1, 1'b1, 1'b1, 32'h0BAD_000F, 16, 0};
    post    = '{8'h03, 32'h7777_0000, 0,   0, 0, 1'b0, 1'b1, 32'h7777_0000, 1,  4};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    cfg_base      = 32'h4444_0000;
    cfg_pass_from = 0;
    cfg_fail_at   = 0;
    cfg_dmode     = 2;
    @(negedge clk);
    @(negedge clk);
    split_mask = 8'hFF;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(bus.chk_req && bus.chk_sel == 3'd4) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach_split4", cyc < 200, 1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    rst_n = 1'b1;
    run_vec("post_reset", post);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_solve_sched.md
# split_solve_sched

Scheduler that drives the split constraint checkers of the solver to find one satisfying assignment. On `start` it fetches a candidate vector from an external generator. It then applies that vector to the enabled split checkers one at a time through a single shared checker port. It reports either the first candidate that passes every enabled split, or failure once the retry budget is used up. It sits between the candidate generator (LFSR/BDD walker) and the split_N constraint blocks, which are muxed externally by `chk_sel`.

## Interface
Parameters:
- `NUM_SPLITS`, 8: number of split checkers; must be ≥ 2.
- `CAND_W`, 32: candidate vector width.
- `MAX_TRIES`, 16: candidates attempted before declaring unsat; must be ≥ 1.
- `SEL_W`, `$clog2(NUM_SPLITS)`: checker index width.
- `TRY_W`, `$clog2(MAX_TRIES+1)`: try counter width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; accepted only in IDLE, ignored otherwise.
- `split_mask` in NUM_SPLITS: bit i=1 means split i is checked; sampled at start acceptance.
- `cand_req` out 1: candidate request; held until `cand_vld`.
- `cand_vld` in 1: candidate valid; ignored when `cand_req`=0.
- `cand_data` in CAND_W: candidate value, captured when `cand_req && cand_vld`.
- `chk_req` out 1: check request to the shared checker.
- `chk_sel` out SEL_W: index of the split being checked.
- `chk_vec` out CAND_W: candidate under test.
- `chk_ack` in 1: checker result valid; ignored when `chk_req`=0.
- `chk_pass` in 1: result, qualified by `chk_ack`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `sat` out 1: result flag; valid from `done`, held until the next accepted start.
- `sol` out CAND_W: satisfying candidate; valid when `sat`=1.
- `tries` out TRY_W: candidates consumed in the last run; valid from `done`.

## Operation
- **Reset.** State=IDLE. `cand_req`, `chk_req`, `busy`, `done` and `sat` are 0. `chk_sel`, `chk_vec`, `sol` and `tries` are 0.
- **IDLE.**
  - `start` → latch `split_mask`, clear `tries` and `sat`, go to FETCH.
  - If the latched mask is all-zero → go directly to DONE with `sat`=1, `sol`=0, `tries`=0. No fetch is made.
- **FETCH.**
  - `cand_req`=1.
  - On `cand_vld`: capture into `chk_vec`, increment `tries`, set `chk_sel` to the lowest enabled index, go to CHECK.
- **CHECK.**
  - `chk_req`=1, `chk_sel` and `chk_vec` held stable.
  - On `chk_ack` with `chk_pass`=1:
    - If a higher enabled index exists, set `chk_sel` to the next enabled index (disabled indices skipped in one cycle, priority scan) and stay in CHECK. `chk_req` stays high.
    - Otherwise go to DONE with `sat`=1 and `sol`=`chk_vec`.
  - On `chk_ack` with `chk_pass`=0:
    - If `tries`==MAX_TRIES, go to DONE with `sat`=0.
    - Otherwise go to FETCH.
- **DONE.** `done`=1 for exactly one cycle, then IDLE.
- **Counter width.** `tries` never exceeds MAX_TRIES; no wrap is possible.
- **Reset mid-run.** An `rst_n` assertion in any state returns the block to reset values immediately. Any pending request is dropped and no `done` is issued.

## Timing
- `start` to `cand_req` high: 1 cycle.
- `cand_vld` to `chk_req` high: next cycle.
- A same-cycle `chk_ack` is allowed. `chk_req` is checked at most once per cycle.
- Per-split cost is 1 cycle plus the checker's latency; the scheduler adds no extra bubble between splits.
- Last `chk_ack` to `done`: 1 cycle.
- `busy` falls in the cycle after `done`.
- `start` asserted in the same cycle as `done` is ignored. `start` is accepted in IDLE only.
- All outputs are registered.

## Test plan
- **Reset values:** assert `rst_n`=0 at any point → every output 0. Deassert, pulse `start` with mask 8'h05, generator returns 32'hA5A5_0001, checker passes all → `chk_sel` sequence 0,2; `done` pulses; `sat`=1, `sol`=32'hA5A5_0001, `tries`=1.
- **Retry:** mask 8'hFF, first candidate fails at split 3, second candidate passes all → `chk_sel` 0..3 then 0..7; `sat`=1, `tries`=2, `sol` = second candidate.
- **Exhaustion:** MAX_TRIES=16, checker always fails at split 0 → exactly 16 `cand_req` handshakes; `done` with `sat`=0, `tries`=16.
- **Empty mask:** mask 0 → `done` 2 cycles after `start`, `sat`=1, no `cand_req` or `chk_req` ever asserted.
- **Handshake stalls and ignored start:**
  - Random `cand_vld`/`chk_ack` delays of 0–5 cycles → `chk_sel`/`chk_vec` stable while `chk_req` is high.
  - `start` pulses while busy → ignored, with no change in behaviour.
- **Reset mid-run:** assert `rst_n` during CHECK at split 4 → outputs 0 immediately, no `done`. A new `start` then runs cleanly from `tries`=0.
